// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if: job/config handshake and buffer/array control bundle for tile_scheduler.
//   master modport (decoder side): drives start, k_tiles, n_tiles, m_rows, acc_keep, stall;
//                                  observes busy, done, buffer reads, accumulator control, n_idx.
//   slave modport (scheduler side): the mirror image.
// Widths must match the derived widths inside tile_scheduler for the chosen parameters.
interface tile_scheduler_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned KT_W   = 5,   // $clog2(MAX_K_TILES+1)
    parameter int unsigned NT_W   = 5,   // $clog2(MAX_N_TILES+1)
    parameter int unsigned M_W    = 6,   // $clog2(A_ROWS+1)
    parameter int unsigned NI_W   = 4    // $clog2(MAX_N_TILES)
);
    logic              start;
    logic [KT_W-1:0]   k_tiles;
    logic [NT_W-1:0]   n_tiles;
    logic [M_W-1:0]    m_rows;
    logic              acc_keep;
    logic              stall;
    logic              busy;
    logic              done;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_rd_addr;
    logic              acc_wr_en;
    logic              acc_clear;
    logic              acc_rd_en;
    logic [ADDR_W-1:0] acc_addr;
    logic [NI_W-1:0]   n_idx;

    modport master (
        output start, k_tiles, n_tiles, m_rows, acc_keep, stall,
        input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
               acc_wr_en, acc_clear, acc_rd_en, acc_addr, n_idx
    );

    modport slave (
        input  start, k_tiles, n_tiles, m_rows, acc_keep, stall,
        output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
               acc_wr_en, acc_clear, acc_rd_en, acc_addr, n_idx
    );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a weight matrix as K x N tiles and the activation matrix in K-slices,
// issuing weight/input buffer reads, accumulator write/clear and flush reads per job.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : tile_scheduler_if.slave carrying job config, stall, status and buffer control
module tile_scheduler #(
    parameter int unsigned SYS_ROWS     = 50,
    parameter int unsigned SYS_COLS     = 50,
    parameter int unsigned A_ROWS       = 50,
    parameter int unsigned MAX_K_TILES  = 16,
    parameter int unsigned MAX_N_TILES  = 16,
    parameter int unsigned DRAIN_CYCLES = SYS_ROWS + SYS_COLS,
    parameter int unsigned ADDR_W       = 16
) (
    input logic             clk,
    input logic             rst_n,
    tile_scheduler_if.slave bus
);
    localparam int unsigned KT_W = $clog2(MAX_K_TILES + 1);
    localparam int unsigned NT_W = $clog2(MAX_N_TILES + 1);
    localparam int unsigned M_W  = $clog2(A_ROWS + 1);
    localparam int unsigned KI_W = $clog2(MAX_K_TILES);
    localparam int unsigned NI_W = $clog2(MAX_N_TILES);
    // One shared phase counter covers weight rows, stream rows, drain wait and flush rows.
    localparam int unsigned CNT_MAX0 = (SYS_ROWS > A_ROWS) ? SYS_ROWS : A_ROWS;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > DRAIN_CYCLES) ? CNT_MAX0 : DRAIN_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle, StLoadW, StStreamA, StDrain, StFlush, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [KT_W-1:0]   k_tiles_q, k_tiles_d;
    logic [NT_W-1:0]   n_tiles_q, n_tiles_d;
    logic [M_W-1:0]    m_rows_q, m_rows_d;
    logic              acc_keep_q, acc_keep_d;
    logic [KI_W-1:0]   k_q, k_d;
    logic [NI_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;

    logic load_last, row_last, drain_last, k_more, n_more, run;

    assign load_last  = (cnt_q == CNT_W'(SYS_ROWS - 1));
    assign row_last   = (cnt_q == CNT_W'(m_rows_q - M_W'(1)));
    assign drain_last = (cnt_q == CNT_W'(DRAIN_CYCLES - 1));
    assign k_more     = (KT_W'(k_q) + KT_W'(1)) < k_tiles_q;
    assign n_more     = (NT_W'(n_q) + NT_W'(1)) < n_tiles_q;
    assign run        = !bus.stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_tiles_q  <= '0;
            n_tiles_q  <= '0;
            m_rows_q   <= '0;
            acc_keep_q <= 1'b0;
            k_q        <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            w_addr_q   <= '0;
            a_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_tiles_q  <= k_tiles_d;
            n_tiles_q  <= n_tiles_d;
            m_rows_q   <= m_rows_d;
            acc_keep_q <= acc_keep_d;
            k_q        <= k_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            w_addr_q   <= w_addr_d;
            a_addr_q   <= a_addr_d;
        end
    end

    // Next state and counters; a stalled active state holds everything.
    always_comb begin
        state_d    = state_q;
        k_tiles_d  = k_tiles_q;
        n_tiles_d  = n_tiles_q;
        m_rows_d   = m_rows_q;
        acc_keep_d = acc_keep_q;
        k_d        = k_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        w_addr_d   = w_addr_q;
        a_addr_d   = a_addr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    k_tiles_d  = bus.k_tiles;
                    n_tiles_d  = bus.n_tiles;
                    m_rows_d   = bus.m_rows;
                    acc_keep_d = bus.acc_keep;
                    k_d        = '0;
                    n_d        = '0;
                    cnt_d      = '0;
                    w_addr_d   = '0;
                    a_addr_d   = '0;
                    if (bus.k_tiles == '0 || bus.n_tiles == '0 || bus.m_rows == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoadW;
                    end
                end
            end
            StLoadW: begin
                if (run) begin
                    w_addr_d = w_addr_q + ADDR_W'(1);
                    if (load_last) begin
                        cnt_d   = '0;
                        state_d = StStreamA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StStreamA: begin
                if (run) begin
                    a_addr_d = a_addr_q + ADDR_W'(1);
                    if (row_last) begin
                        cnt_d = '0;
                        if (k_more) begin
                            k_d     = k_q + KI_W'(1);
                            state_d = StLoadW;
                        end else begin
                            state_d = StDrain;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (run) begin
                    if (drain_last) begin
                        cnt_d   = '0;
                        state_d = StFlush;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StFlush: begin
                if (run) begin
                    if (row_last) begin
                        cnt_d = '0;
                        if (n_more) begin
                            n_d      = n_q + NI_W'(1);
                            k_d      = '0;
                            a_addr_d = '0;
                            state_d  = StLoadW;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs; stall only gates the enables.
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StDone);
        bus.w_rd_en   = (state_q == StLoadW) && run;
        bus.w_rd_addr = w_addr_q;
        bus.a_rd_en   = (state_q == StStreamA) && run;
        bus.a_rd_addr = a_addr_q;
        bus.acc_wr_en = (state_q == StStreamA) && run;
        bus.acc_clear = (state_q == StStreamA) && run && (k_q == '0) && !acc_keep_q;
        bus.acc_rd_en = (state_q == StFlush) && run;
        bus.acc_addr  = '0;
        if (state_q == StStreamA || state_q == StFlush) begin
            bus.acc_addr = ADDR_W'(cnt_q);
        end
        bus.n_idx = n_q;
    end
endmodule
